// File: rtl/arith_add_subtract.sv
// Registered two's-complement adder/subtractor with NZCV status flags.
// One adder serves both operations; subtract inverts operand B and injects a carry-in.
module arith_add_subtract #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             addsub,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       status
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] result_d;
  logic [3:0]       status_d;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;

  always_comb begin
    b_eff    = data2 ^ {WIDTH{addsub}};
    sum      = {1'b0, data1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, addsub};
    result_d = sum[WIDTH-1:0];
    flag_n   = result_d[WIDTH-1];
    flag_z   = (result_d == '0);
    // For subtract, carry out set means no borrow occurred.
    flag_c   = sum[WIDTH];
    flag_v   = (data1[WIDTH-1] == b_eff[WIDTH-1]) && (result_d[WIDTH-1] != data1[WIDTH-1]);
    status_d = {flag_n, flag_z, flag_c, flag_v};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result <= '0;
      status <= 4'b0000;
    end else begin
      result <= result_d;
      status <= status_d;
    end
  end

endmodule

// File: tb/tb_arith_add_subtract.sv
// Scoreboard bench for arith_add_subtract at WIDTH=4: the driver queues expected
// results, a monitor pops and compares one clock after each operation is captured.
module tb_arith_add_subtract;

  localparam int unsigned W = 4;

  logic         clock;
  logic         reset;
  logic [W-1:0] data1;
  logic [W-1:0] data2;
  logic         addsub;
  logic [W-1:0] result;
  logic [3:0]   status;

  typedef struct {
    string      name;
    logic [3:0] r;
    logic [3:0] s;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run;
  int   tests_failed;

  arith_add_subtract #(.WIDTH(W)) dut (
    .clock  (clock),
    .reset  (reset),
    .data1  (data1),
    .data2  (data2),
    .addsub (addsub),
    .result (result),
    .status (status)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [3:0] act_r, input logic [3:0] exp_r,
                       input logic [3:0] act_s, input logic [3:0] exp_s);
    tests_run++;
    if (act_r !== exp_r || act_s !== exp_s) begin
      tests_failed++;
      $display("FAIL %s: got result=%h nzcv=%b, expected result=%h nzcv=%b",
               name, act_r, act_s, exp_r, exp_s);
    end
  endtask

  // Independent reference using signed/unsigned integer arithmetic.
  task automatic model(input int a, input int b, input bit sub,
                       output logic [3:0] r, output logic [3:0] s);
    int full, sa, sb, sres;
    bit c, v;
    sa   = (a >= 8) ? a - 16 : a;
    sb   = (b >= 8) ? b - 16 : b;
    if (sub) begin
      full = a - b;
      c    = (a >= b);
      sres = sa - sb;
    end else begin
      full = a + b;
      c    = (full > 15);
      sres = sa + sb;
    end
    v = (sres > 7) || (sres < -8);
    r = 4'((full + 16) % 16);
    s = {r[3], (r == 4'h0), c, v};
  endtask

  task automatic issue(input string name, input logic [3:0] a, input logic [3:0] b,
                       input logic sub, input logic [3:0] er, input logic [3:0] es);
    exp_t e;
    @(negedge clock);
    data1  = a;
    data2  = b;
    addsub = sub;
    @(posedge clock);
    #1;
    e.name = name;
    e.r    = er;
    e.s    = es;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle, compared mid-cycle.
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.name, result, e.r, status, e.s);
    end
  end

  initial begin
    logic [3:0] mr, ms;
    logic [8:0] idx;
    tests_run    = 0;
    tests_failed = 0;
    reset  = 1'b1;
    data1  = '0;
    data2  = '0;
    addsub = 1'b0;
    #2;
    check("reset_initial", result, 4'h0, status, 4'b0000);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    issue("add_3_4",   4'h3, 4'h4, 1'b0, 4'h7, 4'b0000);
    issue("add_7_1",   4'h7, 4'h1, 1'b0, 4'h8, 4'b1001);
    issue("add_f_1",   4'hF, 4'h1, 1'b0, 4'h0, 4'b0110);
    issue("sub_3_5",   4'h3, 4'h5, 1'b1, 4'hE, 4'b1000);
    issue("sub_5_5",   4'h5, 4'h5, 1'b1, 4'h0, 4'b0110);
    issue("sub_8_1",   4'h8, 4'h1, 1'b1, 4'h7, 4'b0011);
    issue("b2b_add",   4'h1, 4'h1, 1'b0, 4'h2, 4'b0000);
    issue("b2b_sub",   4'h1, 4'h1, 1'b1, 4'h0, 4'b0110);

    for (int i = 0; i < 512; i++) begin
      idx = 9'(i);
      model(int'(idx[4:1]), int'(idx[8:5]), idx[0], mr, ms);
      issue($sformatf("sweep_a%0h_b%0h_s%0d", idx[4:1], idx[8:5], idx[0]),
            idx[4:1], idx[8:5], idx[0], mr, ms);
    end

    // Leave nonzero outputs, then assert reset between edges.
    issue("pre_reset", 4'h6, 4'h3, 1'b0, 4'h9, 4'b1001);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("reset_async", result, 4'h0, status, 4'b0000);
    data1  = 4'hF;
    data2  = 4'h1;
    addsub = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_held", result, 4'h0, status, 4'b0000);
    @(negedge clock);
    reset = 1'b0;
    issue("post_reset", 4'h2, 4'h2, 1'b0, 4'h4, 4'b0000);

    repeat (3) @(negedge clock);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
